// File: rtl/modinv_helper_reduce_precalc.sv
// Modular-halving precalc: streams s and q word-serially and writes both
// halving candidates u = s>>1 and v = (s+q)>>1 (carry into the top bit).
module modinv_helper_reduce_precalc #(
  parameter int unsigned BUFFER_NUM_WORDS = 9,
  parameter int unsigned BUFFER_ADDR_BITS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  output logic                        rdy,
  output logic [BUFFER_ADDR_BITS-1:0] s_addr,
  output logic [BUFFER_ADDR_BITS-1:0] q_addr,
  input  logic [31:0]                 s_din,
  input  logic [31:0]                 q_din,
  output logic [BUFFER_ADDR_BITS-1:0] u_addr,
  output logic [BUFFER_ADDR_BITS-1:0] v_addr,
  output logic                        u_wren,
  output logic                        v_wren,
  output logic [31:0]                 u_dout,
  output logic [31:0]                 v_dout
);

  localparam int unsigned N     = BUFFER_NUM_WORDS;
  localparam int unsigned AW    = BUFFER_ADDR_BITS;
  localparam int unsigned CNT_W = $clog2(N + 4);

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO      = CNT_W'(2);
  localparam logic [CNT_W-1:0] CNT_WR_FIRST = CNT_W'(4);
  localparam logic [CNT_W-1:0] CNT_RD_LAST  = CNT_W'(N);
  localparam logic [CNT_W-1:0] CNT_ADD_LAST = CNT_W'(N + 1);
  localparam logic [CNT_W-1:0] CNT_FLUSH    = CNT_W'(N + 2);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(N + 3);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rdy_q, rdy_d;
  logic [AW-1:0]    rd_addr_q, rd_addr_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic             wren_q, wren_d;
  logic             carry_q, carry_d;
  logic [31:0]      cur_s_q, cur_s_d, prev_s_q, prev_s_d;
  logic [31:0]      cur_sum_q, cur_sum_d, prev_sum_q, prev_sum_d;
  logic [32:0]      sum_c;

  // Sequencer plus registered address/enable, all derived from the next count
  always_comb begin
    cnt_d     = cnt_q;
    rd_addr_d = '0;
    wr_addr_d = '0;
    wren_d    = 1'b0;

    if (cnt_q == '0) begin
      if (ena) cnt_d = CNT_ONE;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end

    rdy_d = (cnt_d == '0);

    if (cnt_d >= CNT_ONE && cnt_d <= CNT_RD_LAST) begin
      rd_addr_d = AW'(cnt_d - CNT_ONE);
    end

    if (cnt_d >= CNT_WR_FIRST && cnt_d <= CNT_LAST) begin
      wren_d    = 1'b1;
      wr_addr_d = AW'(cnt_d - CNT_WR_FIRST);
    end
  end

  // Word-serial adder feeding the two-deep (cur/prev) word pipeline
  always_comb begin
    sum_c      = {1'b0, s_din} + {1'b0, q_din} + {32'b0, carry_q};
    carry_d    = carry_q;
    cur_s_d    = cur_s_q;
    prev_s_d   = prev_s_q;
    cur_sum_d  = cur_sum_q;
    prev_sum_d = prev_sum_q;

    if (cnt_q == CNT_ONE) begin
      carry_d = 1'b0;
    end else if (cnt_q >= CNT_TWO && cnt_q <= CNT_ADD_LAST) begin
      carry_d    = sum_c[32];
      cur_s_d    = s_din;
      prev_s_d   = cur_s_q;
      cur_sum_d  = sum_c[31:0];
      prev_sum_d = cur_sum_q;
    end else if (cnt_q == CNT_FLUSH) begin
      // Virtual word N: zero above s, final carry above the sum
      cur_s_d    = '0;
      prev_s_d   = cur_s_q;
      cur_sum_d  = {31'b0, carry_q};
      prev_sum_d = cur_sum_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      rdy_q      <= 1'b1;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      wren_q     <= 1'b0;
      carry_q    <= 1'b0;
      cur_s_q    <= '0;
      prev_s_q   <= '0;
      cur_sum_q  <= '0;
      prev_sum_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      rdy_q      <= rdy_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      wren_q     <= wren_d;
      carry_q    <= carry_d;
      cur_s_q    <= cur_s_d;
      prev_s_q   <= prev_s_d;
      cur_sum_q  <= cur_sum_d;
      prev_sum_q <= prev_sum_d;
    end
  end

  assign rdy    = rdy_q;
  assign s_addr = rd_addr_q;
  assign q_addr = rd_addr_q;
  assign u_addr = wr_addr_q;
  assign v_addr = wr_addr_q;
  assign u_wren = wren_q;
  assign v_wren = wren_q;
  // Right shift across the word boundary: low bit of the next word on top
  assign u_dout = {cur_s_q[0], prev_s_q[31:1]};
  assign v_dout = {cur_sum_q[0], prev_sum_q[31:1]};

endmodule

// File: tb/tb_modinv_helper_reduce_precalc.sv
// Scoreboard bench for modinv_helper_reduce_precalc (N=9): directed operand
// patterns, ena-ignore, mid-run reset and back-to-back operation checks.
module tb_modinv_helper_reduce_precalc;

  localparam int unsigned N  = 9;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic          rdy;
  logic [AW-1:0] s_addr, q_addr, u_addr, v_addr;
  logic [31:0]   s_din, q_din, u_dout, v_dout;
  logic          u_wren, v_wren;

  modinv_helper_reduce_precalc #(
    .BUFFER_NUM_WORDS(N),
    .BUFFER_ADDR_BITS(AW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .rdy    (rdy),
    .s_addr (s_addr),
    .q_addr (q_addr),
    .s_din  (s_din),
    .q_din  (q_din),
    .u_addr (u_addr),
    .v_addr (v_addr),
    .u_wren (u_wren),
    .v_wren (v_wren),
    .u_dout (u_dout),
    .v_dout (v_dout)
  );

  always #5 clk = ~clk;

  // Synchronous-read s/q buffers
  logic [31:0] s_mem [16];
  logic [31:0] q_mem [16];
  always @(posedge clk) begin
    s_din <= s_mem[s_addr];
    q_din <= q_mem[q_addr];
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   u;
    logic [31:0]   v;
  } wr_t;

  wr_t         exp_q[$];
  string       chk_name[$];
  logic [31:0] chk_act[$];
  logic [31:0] chk_exp[$];

  int n_vec = 0;
  int n_err = 0;

  // Monitor: compares every DUT write and every queued point check
  always @(negedge clk) begin
    wr_t         e;
    string       nm;
    logic [31:0] a, x;
    if (rst_n && (u_wren || v_wren)) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write addr=%0d u=%h v=%h", u_addr, u_dout, v_dout);
      end else begin
        e = exp_q.pop_front();
        if (!(u_wren && v_wren && u_addr == e.addr && v_addr == e.addr &&
              u_dout == e.u && v_dout == e.v)) begin
          n_err++;
          $display("FAIL write got addr=%0d/%0d wren=%b%b u=%h v=%h, required addr=%0d u=%h v=%h",
                   u_addr, v_addr, u_wren, v_wren, u_dout, v_dout, e.addr, e.u, e.v);
        end
      end
    end
    while (chk_name.size() > 0) begin
      nm = chk_name.pop_front();
      a  = chk_act.pop_front();
      x  = chk_exp.pop_front();
      n_vec++;
      if (a !== x) begin
        n_err++;
        $display("FAIL %s got=%h required=%h", nm, a, x);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_name.push_back(nm);
    chk_act.push_back(act);
    chk_exp.push_back(exp);
  endtask

  task automatic load(input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] sr,
                      input logic [31:0] q0, input logic [31:0] q1, input logic [31:0] qr);
    for (int i = 0; i < 16; i++) begin
      s_mem[i] = (i == 0) ? s0 : (i == 1) ? s1 : (i < N) ? sr : 32'h0;
      q_mem[i] = (i == 0) ? q0 : (i == 1) ? q1 : (i < N) ? qr : 32'h0;
    end
  endtask

  task automatic push_exp(input int nw,
                          input logic [31:0] u0, input logic [31:0] um, input logic [31:0] u8,
                          input logic [31:0] v0, input logic [31:0] vm, input logic [31:0] v8);
    wr_t e;
    for (int j = 0; j < nw; j++) begin
      e.addr = AW'(j);
      e.u    = (j == 0) ? u0 : (j == N - 1) ? u8 : um;
      e.v    = (j == 0) ? v0 : (j == N - 1) ? v8 : vm;
      exp_q.push_back(e);
    end
  endtask

  // Call at a negedge; returns at a negedge with rdy=1 (bounded)
  task automatic wait_rdy();
    int k = 0;
    while (!rdy && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!rdy) chk("wait_rdy_timeout", 32'(rdy), 32'd1);
  endtask

  // One operation from a single ena pulse; optional extra ena pulses at cnt=pa/pb
  task automatic run_op(input int pa, input int pb);
    wait_rdy();
    ena = 1'b1;
    @(posedge clk);
    #1 ena = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      ena = (c == pa || c == pb);
      chk($sformatf("rdy_c%0d", c), 32'(rdy), 32'(c == 13));
      chk($sformatf("wren_c%0d", c), 32'(u_wren), 32'(c >= 4 && c <= 12));
    end
    ena = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ena   = 1'b0;
    load(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    chk("reset_rdy", 32'(rdy), 32'd1);
    chk("reset_wren", 32'(u_wren), 32'd0);
    chk("reset_saddr", 32'(s_addr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_rdy", 32'(rdy), 32'd1);

    // s=3, q=2^288-1
    load(32'd3, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    push_exp(N, 32'd1, 32'h0, 32'h0, 32'd1, 32'h0, 32'h8000_0000);
    run_op(0, 0);

    // s = 2^32, q = 0
    load(32'h0, 32'd1, 32'h0, 32'h0, 32'h0, 32'h0);
    push_exp(N, 32'h8000_0000, 32'h0, 32'h0, 32'h8000_0000, 32'h0, 32'h0);
    run_op(0, 0);

    // s = q = all ones
    load(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    push_exp(N, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(0, 0);

    // ena pulses at cnt=3 and cnt=10 are ignored; s=2, q=4
    load(32'd2, 32'h0, 32'h0, 32'd4, 32'h0, 32'h0);
    push_exp(N, 32'd1, 32'h0, 32'h0, 32'd3, 32'h0, 32'h0);
    run_op(3, 10);
    @(negedge clk);
    chk("no_restart_rdy", 32'(rdy), 32'd1);

    // Reset at cnt=6: only words 0 and 1 are written
    load(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    push_exp(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_rdy();
    ena = 1'b1;
    @(posedge clk);
    #1 ena = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_rdy", 32'(rdy), 32'd1);
    chk("abort_wren", 32'(u_wren | v_wren), 32'd0);
    chk("abort_waddr", 32'(u_addr), 32'd0);
    chk("abort_raddr", 32'(s_addr), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_reset_idle", 32'(rdy), 32'd1);
    end
    load(32'h0, 32'd1, 32'h0, 32'h0, 32'h0, 32'h0);
    push_exp(N, 32'h8000_0000, 32'h0, 32'h0, 32'h8000_0000, 32'h0, 32'h0);
    run_op(0, 0);

    // ena held high: three back-to-back operations, one rdy cycle between
    load(32'd3, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int k = 0; k < 3; k++)
      push_exp(N, 32'd1, 32'h0, 32'h0, 32'd1, 32'h0, 32'h8000_0000);
    wait_rdy();
    ena = 1'b1;
    for (int c = 1; c <= 39; c++) begin
      @(negedge clk);
      chk($sformatf("hold_rdy_c%0d", c), 32'(rdy), 32'(c % 13 == 0));
    end
    ena = 1'b0;
    @(negedge clk);
    chk("hold_end_rdy", 32'(rdy), 32'd1);

    repeat (3) @(negedge clk);
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
